ntt_stage_ctrl: RTL and testbench

Address and control sequencer that feeds the radix-2 butterfly unit (BU2_FFT) for an in-place, N-point, decimation-in-frequency NTT. For every stage it issues one butterfly per cycle: a read address pair for the coefficient memory and a twiddle index for the twiddle ROM. It delays write-back addresses to match the read-plus-butterfly latency, so results land in place. It stalls between stages until the pipeline drains, which prevents read-after-write hazards.

---
 rtl/ntt_stage_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_ctrl.sv
// Address/control sequencer for an in-place radix-2 DIF NTT: one butterfly per cycle,
// write-back addresses delayed to match the read-plus-butterfly latency, drain between stages.
module ntt_stage_ctrl #(
    parameter int N_LOG      = 4,
    parameter int PIPE_DELAY = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [N_LOG-1:0] rd_addr_a,
    output logic [N_LOG-1:0] rd_addr_b,
    output logic [N_LOG-2:0] tw_idx,
    output logic             wr_en,
    output logic [N_LOG-1:0] wr_addr_a,
    output logic [N_LOG-1:0] wr_addr_b
);
    localparam int SW = $clog2(N_LOG);
    localparam int CW = $clog2(PIPE_DELAY + 1);
    localparam logic [SW-1:0]    S_LAST     = SW'(N_LOG - 1);
    localparam logic [N_LOG-2:0] J_LAST     = {(N_LOG-1){1'b1}};
    localparam logic [CW-1:0]    DRAIN_LOAD = CW'(PIPE_DELAY);
    localparam logic [CW-1:0]    DRAIN_ONE  = CW'(1);
    localparam logic [N_LOG-1:0] ONE_N      = N_LOG'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SW-1:0]    r_stage, w_stage_nxt;
    logic [N_LOG-2:0] r_bfly,  w_bfly_nxt;
    logic [CW-1:0]    r_drain, w_drain_nxt;

    logic [N_LOG-1:0] w_j_ext, w_half, w_mask, w_k, w_hi, w_addr_a, w_addr_b;
    logic [N_LOG-2:0] w_tw;
    logic             w_issue;

    logic             r_dly_en [PIPE_DELAY];
    logic [N_LOG-1:0] r_dly_a  [PIPE_DELAY];
    logic [N_LOG-1:0] r_dly_b  [PIPE_DELAY];

    // State, stage, butterfly and drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_stage <= {SW{1'b0}};
            r_bfly  <= {(N_LOG-1){1'b0}};
            r_drain <= {CW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_bfly  <= w_bfly_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Next-state logic; counters describe the butterfly presented in the following cycle
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_bfly_nxt  = r_bfly;
        w_drain_nxt = r_drain;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ISSUE;
                    w_stage_nxt = {SW{1'b0}};
                    w_bfly_nxt  = {(N_LOG-1){1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (r_bfly == J_LAST) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end else begin
                    w_bfly_nxt = r_bfly + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain == DRAIN_ONE) begin
                    w_drain_nxt = {CW{1'b0}};
                    if (r_stage == S_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_stage_nxt = r_stage + 1'b1;
                        w_bfly_nxt  = {(N_LOG-1){1'b0}};
                    end
                end else begin
                    w_drain_nxt = r_drain - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Butterfly addressing: j = g*half + k, so g*2*half is just the high part of j shifted left
    always_comb begin
        w_issue  = (w_state_nxt == ST_ISSUE);
        w_j_ext  = {1'b0, w_bfly_nxt};
        w_half   = ONE_N << (S_LAST - w_stage_nxt);
        w_mask   = w_half - ONE_N;
        w_k      = w_j_ext & w_mask;
        w_hi     = w_j_ext & ~w_mask;
        w_addr_a = {w_hi[N_LOG-2:0], 1'b0} | w_k;
        w_addr_b = w_addr_a | w_half;
        w_tw     = w_k[N_LOG-2:0] << w_stage_nxt;
    end

    // Registered read-side and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= {N_LOG{1'b0}};
            rd_addr_b <= {N_LOG{1'b0}};
            tw_idx    <= {(N_LOG-1){1'b0}};
        end else begin
            busy      <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
            done      <= (w_state_nxt == ST_DONE);
            rd_en     <= w_issue;
            rd_addr_a <= w_issue ? w_addr_a : {N_LOG{1'b0}};
            rd_addr_b <= w_issue ? w_addr_b : {N_LOG{1'b0}};
            tw_idx    <= w_issue ? w_tw : {(N_LOG-1){1'b0}};
        end
    end

    // Write-back delay line; shifts in every state so in-flight writes finish during drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_dly_en[i] <= 1'b0;
                r_dly_a[i]  <= {N_LOG{1'b0}};
                r_dly_b[i]  <= {N_LOG{1'b0}};
            end
        end else begin
            r_dly_en[0] <= rd_en;
            r_dly_a[0]  <= rd_addr_a;
            r_dly_b[0]  <= rd_addr_b;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_dly_en[i] <= r_dly_en[i-1];
                r_dly_a[i]  <= r_dly_a[i-1];
                r_dly_b[i]  <= r_dly_b[i-1];
            end
        end
    end

    assign wr_en     = r_dly_en[PIPE_DELAY-1];
    assign wr_addr_a = r_dly_a[PIPE_DELAY-1];
    assign wr_addr_b = r_dly_b[PIPE_DELAY-1];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: a schedule model predicts every strobe and address per cycle,
// and a behavioural butterfly/memory driven by the DUT addresses is compared against a direct DFT mod 12289.
module tb_ntt_stage_ctrl;
    localparam int NL  = 4;
    localparam int PD  = 5;
    localparam int N   = 16;
    localparam int NH  = 8;
    localparam int Q   = 12289;
    localparam int STG = NH + PD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, rd_en, wr_en;
    logic [NL-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [NL-2:0] tw_idx;

    ntt_stage_ctrl #(.N_LOG(NL), .PIPE_DELAY(PD)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int a; int b; int tw;} item_t;
    item_t rd_q[$];
    item_t wr_q[$];
    int    done_q[$];
    int    busy_lo[$];
    int    busy_hi[$];
    int    bu_qa[$];
    int    bu_qb[$];

    int cyc = 0;
    int free_edge = 0;
    int n_cmp = 0;
    int n_err = 0;
    int mem  [N];
    int pend [N];
    int gold [N];
    int w_root;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic int modpow(int b, int e);
        longint r = 1;
        longint x = b;
        int     k = e;
        while (k > 0) begin
            if (k % 2 == 1) r = (r * x) % Q;
            x = (x * x) % Q;
            k = k / 2;
        end
        return int'(r);
    endfunction

    function automatic int bitrev(int v);
        int r = 0;
        for (int i = 0; i < NL; i++) if (((v >> i) & 1) == 1) r = r | (1 << (NL - 1 - i));
        return r;
    endfunction

    // Expected schedule of one transform whose start is sampled at edge e
    function automatic void plan(int e);
        int half, g, k, a;
        for (int s = 0; s < NL; s++) begin
            half = N >> (s + 1);
            for (int j = 0; j < NH; j++) begin
                g = j / half;
                k = j % half;
                a = g * 2 * half + k;
                rd_q.push_back('{e + s * STG + j, a, a + half, k * (1 << s)});
                wr_q.push_back('{e + s * STG + j + PD, a, a + half, 0});
            end
        end
        done_q.push_back(e + NL * STG);
        busy_lo.push_back(e);
        busy_hi.push_back(e + NL * STG - 1);
    endfunction

    // Monitor: compares DUT outputs to the head of the expectation queues every cycle
    always @(negedge clk) begin
        item_t it;
        int    u, v;
        longint dv;
        if (cyc > 20000) begin
            $display("FAIL watchdog cyc=%0d got running expected finished", cyc);
            $fatal(1);
        end
        if (rst) begin
            chk("reset_outputs", int'({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b,
                                        wr_addr_a, wr_addr_b, tw_idx}), 0);
            for (int i = 0; i < N; i++) begin
                mem[i]  = i;
                pend[i] = 0;
            end
            bu_qa.delete();
            bu_qb.delete();
        end else begin
            while (busy_hi.size() > 0 && busy_hi[0] < cyc) begin
                void'(busy_hi.pop_front());
                void'(busy_lo.pop_front());
            end
            chk("busy", int'(busy), (busy_lo.size() > 0 && busy_lo[0] <= cyc) ? 1 : 0);
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                chk("done", int'(done), 1);
            end else begin
                chk("done", int'(done), 0);
            end
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                it = wr_q.pop_front();
                chk("wr_en", int'(wr_en), 1);
                chk("wr_addr_a", int'(wr_addr_a), it.a);
                chk("wr_addr_b", int'(wr_addr_b), it.b);
            end else begin
                chk("wr_en", int'(wr_en), 0);
            end
            if (wr_en && bu_qa.size() > 0) begin
                mem[wr_addr_a] = bu_qa.pop_front();
                mem[wr_addr_b] = bu_qb.pop_front();
                if (pend[wr_addr_a] > 0) pend[wr_addr_a]--;
                if (pend[wr_addr_b] > 0) pend[wr_addr_b]--;
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                it = rd_q.pop_front();
                chk("rd_en", int'(rd_en), 1);
                chk("rd_addr_a", int'(rd_addr_a), it.a);
                chk("rd_addr_b", int'(rd_addr_b), it.b);
                chk("tw_idx", int'(tw_idx), it.tw);
            end else begin
                chk("rd_en", int'(rd_en), 0);
            end
            if (rd_en) begin
                chk("hazard_a", pend[rd_addr_a], 0);
                chk("hazard_b", pend[rd_addr_b], 0);
                pend[rd_addr_a]++;
                pend[rd_addr_b]++;
                u  = mem[rd_addr_a];
                v  = mem[rd_addr_b];
                dv = longint'((u - v + Q) % Q) * longint'(modpow(w_root, int'(tw_idx)));
                bu_qa.push_back((u + v) % Q);
                bu_qb.push_back(int'(dv % Q));
            end
            if (done) begin
                for (int k = 0; k < N; k++) chk("ntt_out", mem[bitrev(k)], gold[k]);
                for (int i = 0; i < N; i++) mem[i] = i;
            end
        end
    end

    task automatic start_run(output int e);
        @(posedge clk); #1;
        while (cyc + 1 < free_edge) begin @(posedge clk); #1; end
        start = 1'b1;
        e = cyc + 1;
        plan(e);
        free_edge = e + NL * STG + 2;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_at(input int tgt);
        while (cyc + 1 < tgt) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Stimulus: idle, directed and random runs, held start, mid-transform reset
    initial begin
        int e;
        int w, acc;
        longint t;
        w = 2;
        w_root = modpow(w, (Q - 1) / N);
        while (modpow(w_root, N / 2) != Q - 1) begin
            w++;
            w_root = modpow(w, (Q - 1) / N);
        end
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int n = 0; n < N; n++) begin
                t   = longint'(n) * longint'(modpow(w_root, (n * k) % N));
                acc = int'((longint'(acc) + t) % Q);
            end
            gold[k] = acc;
        end

        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start_run(e);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            start_run(e);
            pulse_at(e + 1 + int'($urandom_range(0, 52)));
        end

        @(posedge clk); #1;
        while (cyc + 1 < free_edge) begin @(posedge clk); #1; end
        start = 1'b1;
        e = cyc + 1;
        plan(e);
        plan(e + NL * STG + 2);
        free_edge = e + 2 * (NL * STG + 2);
        while (cyc < e + NL * STG + 2) begin @(posedge clk); #1; end
        start = 1'b0;

        start_run(e);
        while (cyc < e + 2 * STG + 3) begin @(posedge clk); #1; end
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_lo.delete();
        busy_hi.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        free_edge = 0;
        repeat (15) @(posedge clk);
        #1;
        start_run(e);
        while (cyc < free_edge + 4) begin @(posedge clk); #1; end
        chk("leftover_expectations", rd_q.size() + wr_q.size() + done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
